// File: rtl/prio_arb_pkg.sv
// Shared types for the multi-mode priority arbiter: arbitration policy and FSM state.
package prio_arb_pkg;

  typedef enum logic [1:0] {
    ARB_FIXED_MSB = 2'd0,
    ARB_FIXED_LSB = 2'd1,
    ARB_RR        = 2'd2,
    ARB_RSVD      = 2'd3
  } arb_mode_e;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

endpackage

// File: rtl/prio_pick_lsb.sv
// Combinational lowest-set-bit picker: returns a one-hot (or zero) vector.
module prio_pick_lsb #(
  parameter int SIZE = 4
) (
  input  logic [SIZE-1:0] req_i,
  output logic [SIZE-1:0] gnt_o
);

  assign gnt_o = req_i & (~req_i + SIZE'(1));

endmodule

// File: rtl/prio_arbiter_multimode.sv
// One-hot arbiter with MSB/LSB/round-robin policy and burst locking via ready/last.
//   state      | meaning
//   ARB_IDLE   | arbitrate every cycle per mode; a non-last transfer opens a burst
//   ARB_LOCKED | grant held on owner until last beat or beat cap
module prio_arbiter_multimode
  import prio_arb_pkg::*;
#(
  parameter int SIZE      = 4,
  parameter int MAX_BEATS = 0,
  parameter int IDX_W     = (SIZE > 1) ? $clog2(SIZE) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       mode,
  input  logic [SIZE-1:0]  req,
  input  logic [SIZE-1:0]  last,
  input  logic             ready,
  output logic [SIZE-1:0]  gnt,
  output logic             gnt_valid,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             locked
);

  localparam int CNT_W = (MAX_BEATS > 0) ? $clog2(MAX_BEATS + 1) : 1;
  localparam int CAP   = (MAX_BEATS > 0) ? MAX_BEATS - 1 : 0;
  localparam logic SINGLE_BEAT = (MAX_BEATS == 1);
  localparam logic CAP_EN      = (MAX_BEATS > 0);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SIZE - 1);

  arb_state_e       state_q, state_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;

  arb_mode_e        mode_e;
  logic [SIZE-1:0]  rr_mask;
  logic [SIZE-1:0]  pick_lsb, pick_msb_rev, pick_rr;
  logic [SIZE-1:0]  idle_gnt, gnt_raw, owner_oh;
  logic [IDX_W-1:0] next_ptr;
  logic             xfer, cap_hit;

  function automatic logic [SIZE-1:0] bit_rev(input logic [SIZE-1:0] v);
    logic [SIZE-1:0] r;
    for (int i = 0; i < SIZE; i++) r[i] = v[SIZE-1-i];
    return r;
  endfunction

  assign mode_e   = arb_mode_e'(mode);
  // Bits at or above the round-robin pointer.
  assign rr_mask  = ~((SIZE'(1) << rr_ptr_q) - SIZE'(1));
  assign owner_oh = SIZE'(1) << owner_q;

  prio_pick_lsb #(.SIZE(SIZE)) u_pick_lsb (.req_i(req),           .gnt_o(pick_lsb));
  prio_pick_lsb #(.SIZE(SIZE)) u_pick_msb (.req_i(bit_rev(req)),  .gnt_o(pick_msb_rev));
  prio_pick_lsb #(.SIZE(SIZE)) u_pick_rr  (.req_i(req & rr_mask), .gnt_o(pick_rr));

  always_comb begin
    idle_gnt = bit_rev(pick_msb_rev);
    case (mode_e)
      ARB_FIXED_LSB: idle_gnt = pick_lsb;
      ARB_RR:        idle_gnt = (pick_rr != '0) ? pick_rr : pick_lsb;
      default:       idle_gnt = bit_rev(pick_msb_rev);
    endcase
  end

  assign gnt_raw   = (state_q == ARB_LOCKED) ? (owner_oh & req) : idle_gnt;
  assign gnt       = rst ? '0 : gnt_raw;
  assign gnt_valid = |gnt;
  assign locked    = (state_q == ARB_LOCKED);

  always_comb begin
    gnt_idx = '0;
    for (int i = 0; i < SIZE; i++) begin
      if (gnt[i]) gnt_idx = gnt_idx | IDX_W'(i);
    end
  end

  assign xfer     = gnt_valid & ready;
  assign next_ptr = (gnt_idx == LAST_IDX) ? '0 : gnt_idx + IDX_W'(1);
  assign cap_hit  = CAP_EN && (beat_cnt_q == CNT_W'(CAP));

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    rr_ptr_d   = rr_ptr_q;
    beat_cnt_d = beat_cnt_q;
    case (state_q)
      ARB_IDLE: begin
        if (xfer) begin
          if (last[gnt_idx] || SINGLE_BEAT) begin
            rr_ptr_d = next_ptr;
          end else begin
            state_d    = ARB_LOCKED;
            owner_d    = gnt_idx;
            beat_cnt_d = CNT_W'(1);
          end
        end
      end
      ARB_LOCKED: begin
        if (xfer) begin
          if (last[gnt_idx] || cap_hit) begin
            state_d    = ARB_IDLE;
            rr_ptr_d   = next_ptr;
            beat_cnt_d = '0;
          end else begin
            beat_cnt_d = beat_cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ARB_IDLE;
      owner_q    <= '0;
      rr_ptr_q   <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

endmodule
